// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port among NUM_REQ writeback
//   requesters (ALU, load unit, multiplier, CSR, ...). A round-robin scan picks
//   one valid requester per cycle and hands it a valid/ready grant. The granted
//   write is registered, so writeEn/dest/writeVal can drive the register file
//   write port directly.
//
// Parameters
//   N                  data width of one register
//   REG_FILE_ADDR_LEN  register address width
//   NUM_REQ            number of requesters (2..8)
//
// Ports
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset
//   stall      in   1 = accept nothing this cycle
//   req_valid  in   [NUM_REQ]                      requester i has a write pending
//   req_dest   in   [NUM_REQ*REG_FILE_ADDR_LEN]    destination of requester i (slice i)
//   req_data   in   [NUM_REQ*N]                    write data of requester i (slice i)
//   req_ready  out  [NUM_REQ]                      one-hot grant, combinational
//   writeEn    out  register-file write enable
//   dest       out  register-file write address
//   writeVal   out  register-file write data
//   grant_id   out  index of the requester behind the current write
//   grant_cnt  out  [NUM_REQ*16] saturating per-requester grant counters
//                   (present only when WB_ARB_STATS_EN is defined)
//
// Build option
//   WB_ARB_STATS_EN : adds grant_cnt and its counters; arbitration and timing
//                     are identical with or without it.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int N                 = 32,
  parameter int REG_FILE_ADDR_LEN = 5,
  parameter int NUM_REQ           = 4,
  localparam int IDX_W            = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 stall,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*REG_FILE_ADDR_LEN-1:0] req_dest,
  input  logic [NUM_REQ*N-1:0]                 req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 writeEn,
  output logic [REG_FILE_ADDR_LEN-1:0]         dest,
  output logic [N-1:0]                         writeVal,
  output logic [IDX_W-1:0]                     grant_id
`ifdef WB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]                grant_cnt
`endif
);

  // Index of the requester 'off' positions after 'base', wrapping modulo
  // NUM_REQ. Works for non-power-of-two NUM_REQ because base+off < 2*NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int               off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + (IDX_W+1)'(off);
    if (sum >= (IDX_W+1)'(NUM_REQ)) begin
      sum = sum - (IDX_W+1)'(NUM_REQ);
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  // Registered state
  logic [IDX_W-1:0]             ptr_q,  ptr_d;
  logic                         we_q,   we_d;
  logic [REG_FILE_ADDR_LEN-1:0] dest_q, dest_d;
  logic [N-1:0]                 val_q,  val_d;
  logic [IDX_W-1:0]             gid_q,  gid_d;

  // Arbitration results
  logic                         win_found_s;
  logic [IDX_W-1:0]             win_idx_s;
  logic [NUM_REQ-1:0]           ready_s;
  logic                         accept_s;
  logic [REG_FILE_ADDR_LEN-1:0] win_dest_s;
  logic [N-1:0]                 win_data_s;

  // Round-robin scan: first valid requester at or after ptr_q wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!win_found_s && req_valid[rr_index(ptr_q, off)]) begin
        win_found_s = 1'b1;
        win_idx_s   = rr_index(ptr_q, off);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant is suppressed during reset and stall; it never looks at req_data.
  always_comb begin
    ready_s = {NUM_REQ{1'b0}};
    if (rst || stall || !win_found_s) begin
      ready_s = {NUM_REQ{1'b0}};
    end else begin
      ready_s[win_idx_s] = 1'b1;
    end
  end

  assign req_ready  = ready_s;
  assign accept_s   = |ready_s;
  assign win_dest_s = req_dest[win_idx_s*REG_FILE_ADDR_LEN +: REG_FILE_ADDR_LEN];
  assign win_data_s = req_data[win_idx_s*N +: N];

  // Next state of the write-port register and the round-robin pointer.
  // A transfer to dest 0 is still a transfer (pointer moves, fields update)
  // but raises no write enable since register 0 is hard-wired zero.
  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    dest_d = dest_q;
    val_d  = val_q;
    gid_d  = gid_q;
    if (accept_s) begin
      ptr_d  = rr_index(win_idx_s, 1);
      we_d   = (win_dest_s != {REG_FILE_ADDR_LEN{1'b0}});
      dest_d = win_dest_s;
      val_d  = win_data_s;
      gid_d  = win_idx_s;
    end else begin
      we_d   = 1'b0;
    end
  end

  // Write-port register and pointer, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= {IDX_W{1'b0}};
      we_q   <= 1'b0;
      dest_q <= {REG_FILE_ADDR_LEN{1'b0}};
      val_q  <= {N{1'b0}};
      gid_q  <= {IDX_W{1'b0}};
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      dest_q <= dest_d;
      val_q  <= val_d;
      gid_q  <= gid_d;
    end
  end

  // A reset arriving while a write is registered must keep that write from
  // committing at the next edge, so the enable is masked by rst.
  assign writeEn  = we_q & ~rst;
  assign dest     = dest_q;
  assign writeVal = val_q;
  assign grant_id = gid_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  // Saturating per-requester grant counters; dest 0 transfers count too.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready_s[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pack counters onto the flat output bus.
  always_comb begin
    grant_cnt = {(NUM_REQ*16){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

  regfile_wb_arbiter_checker #(
    .NUM_REQ (NUM_REQ)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .req_valid (req_valid),
    .req_ready (req_ready)
  );

endmodule

// -----------------------------------------------------------------------------
// regfile_wb_arbiter_checker
//   Protocol properties of the grant vector: at most one grant, only to a
//   valid requester, and none while stalled.
//   Ports: clk, rst, stall, req_valid, req_ready (all inputs).
// -----------------------------------------------------------------------------
module regfile_wb_arbiter_checker #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst,
  input logic               stall,
  input logic [NUM_REQ-1:0] req_valid,
  input logic [NUM_REQ-1:0] req_ready
);

  a_onehot_grant : assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  a_grant_valid : assert property (@(posedge clk) disable iff (rst)
    ((req_ready & ~req_valid) == {NUM_REQ{1'b0}}));

  a_stall_blocks : assert property (@(posedge clk) disable iff (rst)
    stall |-> (req_ready == {NUM_REQ{1'b0}}));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_dest;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             writeEn;
  logic [AW-1:0]    dest;
  logic [DW-1:0]    writeVal;
  logic [1:0]       grant_id;
`ifdef WB_ARB_STATS_EN
  logic [NR*16-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N(DW), .REG_FILE_ADDR_LEN(AW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_data  (req_data),
    .req_ready (req_ready),
    .writeEn   (writeEn),
    .dest      (dest),
    .writeVal  (writeVal),
`ifdef WB_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .grant_id  (grant_id)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stimulus state
  bit            v_s  [NR];
  logic [AW-1:0] d_s  [NR];
  logic [DW-1:0] x_s  [NR];
  bit            rst_s;
  bit            stall_s;

  // Reference model state
  int            m_ptr;
  bit            m_we;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_val;
  int            m_gid;
  int            m_cnt [NR];
  int            last_acc;

  task automatic drive();
    rst   = rst_s;
    stall = stall_s;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = v_s[i];
      req_dest[i*AW +: AW]  = d_s[i];
      req_data[i*DW +: DW]  = x_s[i];
    end
  endtask

  // Who should be granted with the current inputs: first valid requester
  // from the pointer onward, nobody under reset or stall.
  function automatic int winner();
    if (rst_s || stall_s) return -1;
    for (int k = 0; k < NR; k++) begin
      if (v_s[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_dest = '0; m_val = '0; m_gid = 0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
  endtask

  task automatic check_now();
    int w;
    w = winner();
    check_eq("ready", req_ready, (w < 0) ? 64'd0 : (64'd1 << w));
    check_eq("writeEn", writeEn, m_we && !rst_s);
    check_eq("dest", dest, m_dest);
    check_eq("writeVal", writeVal, m_val);
    check_eq("grant_id", grant_id, m_gid);
`ifdef WB_ARB_STATS_EN
    for (int i = 0; i < NR; i++) check_eq("grant_cnt", grant_cnt[i*16 +: 16], m_cnt[i]);
`endif
  endtask

  // One cycle: apply inputs, check against model, clock, advance model.
  task automatic step();
    int w;
    drive();
    #1;
    check_now();
    w = winner();
    @(posedge clk);
    if (rst_s) begin
      model_reset();
      w = -1;
    end else if (w >= 0) begin
      m_ptr  = (w + 1) % NR;
      m_we   = (d_s[w] != 0);
      m_dest = d_s[w];
      m_val  = x_s[w];
      m_gid  = w;
      if (m_cnt[w] < 65535) m_cnt[w]++;
    end else begin
      m_we = 1'b0;
    end
    last_acc = w;
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      v_s[i] = 1'b0; d_s[i] = '0; x_s[i] = '0;
    end
  endtask

  initial begin
    clear_reqs();
    stall_s = 1'b0;
    last_acc = -1;

    // 1: reset for two cycles with everybody valid
    rst_s = 1'b1;
    for (int i = 0; i < NR; i++) begin
      v_s[i] = 1'b1; d_s[i] = AW'(i + 1); x_s[i] = 32'h1000 + i;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("t1_ready_in_rst", req_ready, 0);
    check_now();

    // 2: single requester, visible one cycle later
    rst_s = 1'b0;
    clear_reqs();
    v_s[1] = 1'b1; d_s[1] = 5'd5; x_s[1] = 32'hDEADBEEF;
    drive(); #1;
    check_eq("t2_ready", req_ready, 4'b0010);
    step();
    check_eq("t2_we", writeEn, 1'b1);
    check_eq("t2_dest", dest, 5'd5);
    check_eq("t2_val", writeVal, 32'hDEADBEEF);
    check_eq("t2_gid", grant_id, 2'd1);

    // 3: all valid and held after a reset -> 0,1,2,3,0
    clear_reqs();
    rst_s = 1'b1; step(); rst_s = 1'b0;
    for (int i = 0; i < NR; i++) begin
      v_s[i] = 1'b1; d_s[i] = AW'(i + 10); x_s[i] = 32'hA000 + i;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("t3_gid", grant_id, k % NR);
      check_eq("t3_we", writeEn, 1'b1);
    end

    // 4: dest 0 request is accepted, pointer moves to 3, no write enable
    clear_reqs();
    v_s[2] = 1'b1; d_s[2] = 5'd0; x_s[2] = 32'h12345678;
    drive(); #1;
    check_eq("t4_ready", req_ready, 4'b0100);
    step();
    check_eq("t4_we", writeEn, 1'b0);
    for (int i = 0; i < NR; i++) begin
      v_s[i] = 1'b1; d_s[i] = AW'(i + 20);
    end
    drive(); #1;
    check_eq("t4_ptr", req_ready, 4'b1000);
    step();

    // 5: stall holds the request off, then it goes through
    clear_reqs();
    step();
    v_s[0] = 1'b1; d_s[0] = 5'd7; x_s[0] = 32'hCAFE0007;
    stall_s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(); #1;
      check_eq("t5_stall_ready", req_ready, 0);
      step();
    end
    stall_s = 1'b0;
    drive(); #1;
    check_eq("t5_ready", req_ready, 4'b0001);
    step();
    check_eq("t5_we", writeEn, 1'b1);
    check_eq("t5_dest", dest, 5'd7);
    stall_s = 1'b1;
    drive(); #1;
    check_eq("t5_we_under_stall", writeEn, 1'b1);
    step();
    check_eq("t5_we_after", writeEn, 1'b0);
    stall_s = 1'b0;

    // 6: reset right after an accept kills the write
    clear_reqs();
    v_s[1] = 1'b1; d_s[1] = 5'd9; x_s[1] = 32'h99;
    step();
    check_eq("t6_we_pre", writeEn, 1'b1);
    clear_reqs();
    rst_s = 1'b1;
    drive(); #1;
    check_eq("t6_we_masked", writeEn, 1'b0);
    step();
    check_eq("t6_we", writeEn, 1'b0);
    check_eq("t6_dest", dest, 0);
    rst_s = 1'b0;

    // Random phase: requesters hold until accepted
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (last_acc == i || !v_s[i]) begin
          v_s[i] = (last_acc == i) ? bit'($urandom_range(0, 1)) : bit'($urandom_range(0, 1));
          d_s[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
          x_s[i] = $urandom;
        end
      end
      stall_s = ($urandom_range(0, 4) == 0);
      rst_s   = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
